// File: rtl/encoder_pkg.sv
// Shared types for the bit-scan encoder: FSM state encoding and default sizing.
package encoder_pkg;

  localparam int DEFAULT_OUT_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/find_first_set.sv
// Combinational lowest-set-bit search over the pending vector, plus a flag
// telling whether exactly one bit remains.
module find_first_set #(
  parameter int OUT_WIDTH = 5
) (
  input  logic [(1 << OUT_WIDTH)-1:0] pend,
  output logic [OUT_WIDTH-1:0]        idx,
  output logic                        one_hot
);

  localparam int N = 1 << OUT_WIDTH;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) idx = OUT_WIDTH'(i);
    end
  end

  assign one_hot = (pend != '0) && ((pend & (pend - N'(1))) == '0);

endmodule

// File: rtl/bitscan_encoder.sv
// Accepts a request vector and emits the index of every active bit, lowest
// first, one beat per handshake; an empty vector yields a single "none" beat.
module bitscan_encoder
  import encoder_pkg::*;
#(
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter int ACTIVE    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1 << OUT_WIDTH)-1:0] in_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_idx,
  output logic                        out_last,
  output logic                        out_none
);

  localparam int N = 1 << OUT_WIDTH;

  state_t               state, state_nxt;
  logic [N-1:0]         pend, pend_nxt;
  logic [OUT_WIDTH-1:0] ffs_idx;
  logic                 ffs_one;
  logic                 empty;
  logic                 emit;
  logic                 last;

  find_first_set #(.OUT_WIDTH(OUT_WIDTH)) u_ffs (
    .pend    (pend),
    .idx     (ffs_idx),
    .one_hot (ffs_one)
  );

  assign emit  = (state == EMIT);
  assign empty = (pend == '0);
  // An empty capture still produces one terminating beat.
  assign last  = ffs_one || empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pend_nxt  = (ACTIVE != 0) ? in_vec : ~in_vec;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_nxt = pend & ~(N'(1) << ffs_idx);
          if (last) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = emit;
  assign out_idx   = emit ? ffs_idx : '0;
  assign out_last  = emit && last;
  assign out_none  = emit && empty;

endmodule

// File: doc/bitscan_encoder.md
BITSCAN_ENCODER -- requirements
Module: bitscan_encoder

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 5: index width; vector width N = 1 << OUT_WIDTH (32 by default).
REQ-002 SHALL have parameter ACTIVE, default 1: active level of vector bits (1 = HIGH marks a bit, 0 = LOW marks a bit).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_vec is offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 SHALL have port in_vec  input  N  request vector.
REQ-008 SHALL have port out_valid  output  1  out_idx, out_last and out_none are valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-010 SHALL have port out_idx  output  OUT_WIDTH  index of the current active bit.
REQ-011 SHALL have port out_last  output  1  current beat is the final beat for this vector.
REQ-012 SHALL have port out_none  output  1  the accepted vector had no active bit.

Function
REQ-013 SHALL be an FSM with states IDLE and EMIT only.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in EMIT; there is no input/output overlap.
REQ-015 SHALL, in IDLE with in_valid=1, capture pend = (ACTIVE ? in_vec : ~in_vec) and enter EMIT on the next edge.
REQ-016 SHALL assert out_valid in the cycle immediately after acceptance, giving a latency of 1 cycle.
REQ-017 SHALL drive out_idx as the lowest index i with pend[i]=1, i.e. in ascending order, bit 0 first.
REQ-018 SHALL drive out_last=1 when pend has exactly one bit set.
REQ-019 SHALL, when the captured pend is all-zero, emit exactly one beat with out_none=1, out_last=1, out_idx=0.
REQ-020 SHALL drive out_none=0 on every beat of a non-empty vector.
REQ-021 SHALL, on out_valid && out_ready, clear pend[out_idx]; if out_last=1 it SHALL return to IDLE on that edge.
REQ-022 SHALL hold out_idx, out_last and out_none stable while out_valid=1 && out_ready=0; pend changes only on a handshake.
REQ-023 SHALL emit exactly popcount(pend) beats per vector, or 1 beat when pend is empty; a full vector (all N bits) yields N beats with indices 0..N-1.
REQ-024 SHALL ignore in_valid and in_vec while in EMIT.
REQ-025 SHALL sustain one beat per cycle while out_ready=1; the next vector is accepted no earlier than the cycle after the last beat.
REQ-026 SHALL drive out_idx, out_last and out_none to 0 whenever out_valid=0.

Reset
REQ-027 SHALL, on rst_n=0, immediately and asynchronously set state=IDLE and pend=0, giving in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0.
REQ-028 SHALL, on reset asserted mid-EMIT, discard all remaining beats; no beat is emitted after reset deasserts until a new vector is accepted.
REQ-029 SHALL use rst_n deassertion as given; synchronizing rst_n deassertion is outside this block.

Structure
REQ-030 SHALL place the state enum (IDLE, EMIT) in a shared package encoder_pkg.
REQ-031 SHALL implement the lowest-set-bit search as one combinational sub-module find_first_set.
REQ-032 find_first_set SHALL take pend (N bits) and return the index (OUT_WIDTH bits) and a one-hot flag.
REQ-033 SHALL target 120-400 lines of RTL in total.

Verification
REQ-034 The bench SHALL cover: in_vec=32'h8000_0011, ACTIVE=1, out_ready=1 -> beats idx 0,4,31, out_last only on 31, in_ready high again the cycle after idx 31.
REQ-035 The bench SHALL cover: in_vec=0 -> one beat with out_none=1, out_last=1, out_idx=0, then IDLE.
REQ-036 The bench SHALL cover: ACTIVE=0, in_vec=32'hFFFF_FFFB -> single beat idx 2, out_last=1.
REQ-037 The bench SHALL cover: in_vec=32'h0000_0006 with out_ready low for 3 cycles -> idx 1 held stable for 3 cycles, then beats 1,2.
REQ-038 The bench SHALL cover: in_vec=32'hFFFF_FFFF -> 32 consecutive beats idx 0..31, in_valid toggling during EMIT is ignored.
REQ-039 The bench SHALL cover: rst_n pulsed low after beat idx 4 of 32'h0000_00F0 -> out_valid drops immediately, in_ready=1, no idx 5..7 emitted.
